// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-add multiplier with an internal controller.
// One multiplier bit is consumed per CALC cycle. The loop exits early as soon
// as the remaining multiplier bits are all zero. Signed operands are reduced
// to magnitudes, multiplied unsigned, and the sign is applied in FIX.
//
// Ports:
//   Clk         clock, rising edge
//   reset       synchronous active-high reset
//   start       request, accepted only in IDLE
//   signed_mode 1 = two's complement operands/product (sampled with start)
//   a_data      multiplicand, WA bits (sampled with start)
//   b_data      multiplier, WB bits (sampled with start)
//   P           product, WA+WB bits, held until the next FIX
//   busy        high from the cycle after an accepted start through DONE
//   done        one-cycle pulse when P is valid
//   b_zero      high with done when the captured |b| was zero
module mult_seq_ctrl #(
  parameter int unsigned WA = 8,
  parameter int unsigned WB = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WA-1:0]    a_data,
  input  logic [WB-1:0]    b_data,
  output logic [WA+WB-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             b_zero
);

  localparam int unsigned WP = WA + WB;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [WP-1:0]   a_reg;
  logic [WP-1:0]   acc;
  logic [WB-1:0]   b_reg;
  logic            neg;
  logic            zflag;

  logic            a_neg, b_neg;
  logic [WA-1:0]   a_mag;
  logic [WB-1:0]   b_mag;

  // Magnitudes of the raw operands; the most-negative value maps to
  // 2^(W-1), which still fits as a W-bit unsigned number.
  always_comb begin
    a_neg = signed_mode & a_data[WA-1];
    b_neg = signed_mode & b_data[WB-1];
    a_mag = a_neg ? -a_data : a_data;
    b_mag = b_neg ? -b_data : b_data;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (b_reg == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the state flop only, so nothing combinational reaches
  // them from the inputs.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    b_zero = (state == DONE) & zflag;
  end

  // Datapath
  always_ff @(posedge Clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      zflag <= 1'b0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= WP'(a_mag);
            b_reg <= b_mag;
            acc   <= '0;
            neg   <= signed_mode & (a_data[WA-1] ^ b_data[WB-1]);
            zflag <= (b_mag == '0);
          end
        end
        CALC: begin
          if (b_reg != '0) begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
          end
        end
        FIX: P <= neg ? -acc : acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // 8x4 instance
  logic        st8, sm8, busy8, done8, bz8;
  logic [7:0]  a8;
  logic [3:0]  b8;
  logic [11:0] P8;
  // 5x7 instance
  logic        st57, sm57, busy57, done57, bz57;
  logic [4:0]  a57;
  logic [6:0]  b57;
  logic [11:0] P57;
  // 16x16 instance
  logic        st16, sm16, busy16, done16, bz16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [31:0] P16;

  mult_seq_ctrl #(.WA(8), .WB(4)) u8 (
    .Clk(Clk), .reset(reset), .start(st8), .signed_mode(sm8),
    .a_data(a8), .b_data(b8), .P(P8), .busy(busy8), .done(done8), .b_zero(bz8));

  mult_seq_ctrl #(.WA(5), .WB(7)) u57 (
    .Clk(Clk), .reset(reset), .start(st57), .signed_mode(sm57),
    .a_data(a57), .b_data(b57), .P(P57), .busy(busy57), .done(done57), .b_zero(bz57));

  mult_seq_ctrl #(.WA(16), .WB(16)) u16 (
    .Clk(Clk), .reset(reset), .start(st16), .signed_mode(sm16),
    .a_data(a16), .b_data(b16), .P(P16), .busy(busy16), .done(done16), .b_zero(bz16));

  typedef struct {
    logic [31:0] p;
    bit          bz;
    int          cyc;
  } exp_t;

  exp_t q8[$], q57[$], q16[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic busy_of(input int inst);
    case (inst)
      0:       return busy8;
      1:       return busy57;
      default: return busy16;
    endcase
  endfunction

  // Reference model: integer multiply of sign-interpreted operands.
  function automatic void ref_model(input int wa, input int wb, input bit sm,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output bit bz, output int lat);
    longint av, bv, prod, bm;
    int k;
    av = longint'(a);
    bv = longint'(b);
    if (sm && a[wa-1]) av = av - (longint'(1) << wa);
    if (sm && b[wb-1]) bv = bv - (longint'(1) << wb);
    prod = av * bv;
    p  = 32'(prod & ((longint'(1) << (wa + wb)) - 1));
    bm = (bv < 0) ? -bv : bv;
    k  = 0;
    while ((bm >> k) != 0) k++;
    bz  = (bm == 0);
    lat = k + 2;
  endfunction

  // Drive one start pulse; the expected done falls lat edges after the
  // accepting edge.
  task automatic issue(input int inst, input bit sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ep, input bit ebz,
                       input int lat, input bit push);
    exp_t e;
    @(posedge Clk); #1;
    case (inst)
      0: begin sm8 = sm;  a8 = a[7:0];   b8 = b[3:0];   st8 = 1'b1;  end
      1: begin sm57 = sm; a57 = a[4:0];  b57 = b[6:0];  st57 = 1'b1; end
      default: begin sm16 = sm; a16 = a[15:0]; b16 = b[15:0]; st16 = 1'b1; end
    endcase
    @(posedge Clk); #1;
    st8 = 1'b0; st57 = 1'b0; st16 = 1'b0;
    e.p = ep; e.bz = ebz; e.cyc = cyc + lat;
    if (push) begin
      case (inst)
        0:       q8.push_back(e);
        1:       q57.push_back(e);
        default: q16.push_back(e);
      endcase
    end
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (busy_of(inst) && n < 200);
    if (busy_of(inst)) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst=%0d: busy still 1 after 200 cycles, required 0", inst);
    end
  endtask

  task automatic rand_test(input int inst, input int wa, input int wb);
    logic [31:0] a, b, p;
    bit sm, bz;
    int lat;
    for (int n = 0; n < 100; n++) begin
      sm = bit'($urandom_range(0, 1));
      a  = 32'($urandom) & 32'((longint'(1) << wa) - 1);
      b  = 32'($urandom) & 32'((longint'(1) << wb) - 1);
      ref_model(wa, wb, sm, a, b, p, bz, lat);
      issue(inst, sm, a, b, p, bz, lat, 1'b1);
      wait_idle(inst);
    end
  endtask

  // Monitor: consumes one expectation per done pulse.
  task automatic mon(input int inst, input logic [31:0] p, input bit bz);
    exp_t e;
    bit have;
    have = 1'b0;
    case (inst)
      0:       if (q8.size() > 0)  begin e = q8.pop_front();  have = 1'b1; end
      1:       if (q57.size() > 0) begin e = q57.pop_front(); have = 1'b1; end
      default: if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done inst=%0d: got done=1 P=0x%0h, required no done", inst, p);
    end else begin
      chk($sformatf("product[%0d]", inst), p, e.p);
      chk($sformatf("b_zero[%0d]", inst), 32'(bz), 32'(e.bz));
      chk($sformatf("latency[%0d]", inst), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge Clk) begin
    if (done8)  mon(0, 32'(P8), bz8);
    if (done57) mon(1, 32'(P57), bz57);
    if (done16) mon(2, P16, bz16);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    st8 = 1'b1;  sm8 = 1'b0;  a8 = 8'd13;   b8 = 4'd11;
    st57 = 1'b1; sm57 = 1'b0; a57 = 5'd3;   b57 = 7'd3;
    st16 = 1'b1; sm16 = 1'b0; a16 = 16'd3;  b16 = 16'd3;

    // Reset with start held high
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_P", 32'(P8), 32'h0);
    chk("reset_busy", 32'(busy8), 32'h0);
    chk("reset_done", 32'(done8), 32'h0);
    chk("reset_b_zero", 32'(bz8), 32'h0);
    @(posedge Clk); #1;
    reset = 1'b0;
    st8 = 1'b0; st57 = 1'b0; st16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("idle_busy", 32'(busy8), 32'h0);
      chk("idle_P", 32'(P8), 32'h0);
    end

    // 13 x 11 unsigned with cycle-by-cycle busy/done window
    issue(0, 1'b0, 32'd13, 32'd11, 32'h08F, 1'b0, 6, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge Clk);
      chk($sformatf("busy_t0+%0d", j), 32'(busy8), 32'(j <= 7));
      chk($sformatf("done_t0+%0d", j), 32'(done8), 32'(j == 7));
    end

    // Early exit and single-bit multiplier
    issue(0, 1'b0, 32'd200, 32'd0, 32'h000, 1'b1, 2, 1'b1);
    wait_idle(0);
    issue(0, 1'b0, 32'd200, 32'd1, 32'h0C8, 1'b0, 3, 1'b1);
    wait_idle(0);

    // Signed
    issue(0, 1'b1, 32'hFD, 32'h5, 32'hFF1, 1'b0, 5, 1'b1);
    wait_idle(0);
    issue(0, 1'b1, 32'h80, 32'h8, 32'h400, 1'b0, 6, 1'b1);
    wait_idle(0);
    issue(0, 1'b1, 32'h80, 32'h7, 32'hC80, 1'b0, 5, 1'b1);
    wait_idle(0);

    // Start while busy is ignored
    issue(0, 1'b0, 32'd13, 32'd11, 32'h08F, 1'b0, 6, 1'b1);
    @(posedge Clk); #1;
    st8 = 1'b1; a8 = 8'd3; b8 = 4'd2;
    @(posedge Clk); #1;
    st8 = 1'b0;
    wait_idle(0);
    repeat (4) @(negedge Clk);

    // Reset mid-operation
    issue(0, 1'b0, 32'd13, 32'd11, 32'h0, 1'b0, 0, 1'b0);
    @(posedge Clk);
    @(posedge Clk); #1;
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(negedge Clk);
    chk("abort_P", 32'(P8), 32'h0);
    chk("abort_busy", 32'(busy8), 32'h0);
    repeat (10) @(negedge Clk);
    issue(0, 1'b0, 32'd3, 32'd5, 32'h00F, 1'b0, 5, 1'b1);
    wait_idle(0);

    // Other configurations
    issue(2, 1'b0, 32'hFFFF, 32'hFFFF, 32'hFFFE0001, 1'b0, 18, 1'b1);
    wait_idle(2);
    issue(1, 1'b0, 32'd31, 32'd127, 32'd3937, 1'b0, 9, 1'b1);
    wait_idle(1);

    rand_test(0, 8, 4);
    rand_test(1, 5, 7);
    rand_test(2, 16, 16);

    repeat (5) @(negedge Clk);
    chk("sb_drain8", 32'(q8.size()), 32'h0);
    chk("sb_drain57", 32'(q57.size()), 32'h0);
    chk("sb_drain16", 32'(q16.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
